// File: rtl/mmio_console.sv
// Memory-mapped console: a 4-register window on the data bus that queues written
// words in a circular FIFO and drains them to a valid/ready sink.
module mmio_console #(
    parameter logic [23:0] BASE_ADDR = 24'hFFFF00,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] address_bus,
    input  logic [31:0] wdata_bus,
    input  logic [1:0]  control_bus,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq_empty
);

    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [23:0]   offset;
    logic          in_win, wr_en, rd_en;
    logic          push_req, push_ok, pop, flush, clr_ovf;
    logic          empty, full;
    logic [31:0]   status;

    // Bus decode and FIFO handshake qualifiers
    always_comb begin
        offset   = address_bus - BASE_ADDR;
        in_win   = (offset[23:2] == 22'd0);
        wr_en    = in_win && control_bus[0];
        rd_en    = in_win && (control_bus == 2'b10);
        push_req = wr_en && (offset[1:0] == 2'd0);
        flush    = wr_en && (offset[1:0] == 2'd2) && wdata_bus[0];
        clr_ovf  = wr_en && (offset[1:0] == 2'd2) && wdata_bus[1];
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop      = !empty && out_ready;
        // a same-cycle pop frees the slot, so a push into a full FIFO still lands
        push_ok  = push_req && (!full || pop);
        status           = '0;
        status[0]        = empty;
        status[1]        = full;
        status[2]        = ovf_q;
        status[AW+8:8]   = count_q;
    end

    // Next-state for pointers, count, sticky overflow, irq pulse and read data
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        irq_d    = 1'b0;
        rdata_d  = rdata_q;

        if (rd_en) begin
            rdata_d = (offset[1:0] == 2'd1) ? status : 32'd0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
            irq_d = pop && !push_ok && (count_q == CW'(1));
        end

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_bus;
        end
    end

    assign hit       = in_win && (control_bus != 2'b00);
    assign out_valid = !empty;
    assign out_data  = empty ? 32'd0 : mem_q[rd_ptr_q];
    assign rdata     = rdata_q;
    assign irq_empty = irq_q;

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: directed scenarios plus a randomized burst test
// checked against a queue-based model of the console.
module tb_mmio_console;

    localparam logic [23:0] BASE  = 24'hFFFF00;
    localparam int unsigned DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [23:0] address_bus;
    logic [31:0] wdata_bus;
    logic [1:0]  control_bus;
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        irq_empty;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    logic [31:0] mq[$];
    logic        m_ovf;
    logic        m_irq;
    logic [31:0] m_rdata;

    mmio_console #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .reset(reset), .address_bus(address_bus), .wdata_bus(wdata_bus),
        .control_bus(control_bus), .rdata(rdata), .hit(hit), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .irq_empty(irq_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc_write(input logic [23:0] off, input logic [31:0] data);
        address_bus = BASE + off;
        wdata_bus   = data;
        control_bus = 2'b01;
        @(posedge clk); #1;
        control_bus = 2'b00;
    endtask

    task automatic cyc_read(input logic [23:0] off);
        address_bus = BASE + off;
        control_bus = 2'b10;
        @(posedge clk); #1;
        control_bus = 2'b00;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [23:0] d;
        logic        inwin, wr, rd, popn;
        logic [31:0] st;
        d     = address_bus - BASE;
        inwin = (d < 24'd4);
        wr    = inwin && control_bus[0];
        rd    = inwin && (control_bus == 2'b10);
        st    = (32'(mq.size()) << 8) | {29'd0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
        popn  = (mq.size() != 0) && out_ready;
        m_irq = 1'b0;
        if (rd) m_rdata = (d == 24'd1) ? st : 32'd0;
        if (wr && d == 24'd2 && wdata_bus[0]) begin
            mq.delete();
        end else begin
            if (popn) void'(mq.pop_front());
            if (wr && d == 24'd0) begin
                if (mq.size() < DEPTH) mq.push_back(wdata_bus);
                else m_ovf = 1'b1;
            end
            if (popn && mq.size() == 0) m_irq = 1'b1;
        end
        if (wr && d == 24'd2 && wdata_bus[1]) m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0; control_bus = 2'b00;
        address_bus = 24'd0; wdata_bus = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        vectors++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        vectors++; if (irq_empty !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_empty); end
        reset = 1'b0;
        address_bus = BASE + 24'd1; control_bus = 2'b10;
        #1;
        vectors++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_status got=%b exp=1", hit); end
        @(posedge clk); #1;
        control_bus = 2'b00;
        vectors++; if (rdata !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=1", rdata); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid2 got=%b exp=0", out_valid); end
        address_bus = BASE + 24'd4; control_bus = 2'b01;
        #1;
        vectors++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_outside got=%b exp=0", hit); end
        address_bus = BASE; control_bus = 2'b00;
        #1;
        vectors++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_idle got=%b exp=0", hit); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h41; exp_w[1] = 32'h42; exp_w[2] = 32'h43;
        out_ready = 1'b0;
        cyc_write(24'd0, 32'h41);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        vectors++; if (out_data !== 32'h41) begin errors++; $display("FAIL basic_head got=%h exp=41", out_data); end
        cyc_write(24'd0, 32'h42);
        cyc_write(24'd0, 32'h43);
        cyc_read(24'd1);
        vectors++; if (rdata !== 32'h300) begin errors++; $display("FAIL basic_status got=%h exp=300", rdata); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i] || irq_empty !== 1'b0) begin
                errors++;
                $display("FAIL basic_drain%0d got v=%b d=%h irq=%b exp v=1 d=%h irq=0", i, out_valid, out_data, irq_empty, exp_w[i]);
            end
        end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || irq_empty !== 1'b1) begin errors++; $display("FAIL basic_irq got v=%b irq=%b exp v=0 irq=1", out_valid, irq_empty); end
        @(negedge clk);
        vectors++; if (irq_empty !== 1'b0) begin errors++; $display("FAIL basic_irq_pulse got=%b exp=0", irq_empty); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int v = 0; v <= 16; v++) cyc_write(24'd0, 32'(v));
        cyc_read(24'd1);
        vectors++; if (rdata !== 32'h1006) begin errors++; $display("FAIL ovf_status got=%h exp=1006", rdata); end
        vectors++; if (out_data !== 32'd0) begin errors++; $display("FAIL ovf_head got=%h exp=0", out_data); end
        cyc_write(24'd2, 32'h2);
        cyc_read(24'd1);
        vectors++; if (rdata !== 32'h1002) begin errors++; $display("FAIL ovf_clear got=%h exp=1002", rdata); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] e;
        address_bus = BASE; wdata_bus = 32'hAA; control_bus = 2'b01; out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (out_data !== 32'd0) begin errors++; $display("FAIL fpp_head got=%h exp=0", out_data); end
        @(posedge clk); #1;
        control_bus = 2'b00; out_ready = 1'b0;
        cyc_read(24'd1);
        vectors++; if (rdata !== 32'h1002) begin errors++; $display("FAIL fpp_status got=%h exp=1002", rdata); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? 32'(i + 1) : 32'hAA;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                errors++;
                $display("FAIL fpp_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, e);
            end
        end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || irq_empty !== 1'b1) begin errors++; $display("FAIL fpp_end got v=%b irq=%b exp v=0 irq=1", out_valid, irq_empty); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc_write(24'd0, $urandom);
        address_bus = BASE + 24'd2; wdata_bus = 32'h1; control_bus = 2'b01; out_ready = 1'b1;
        @(posedge clk); #1;
        control_bus = 2'b00;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        vectors++; if (irq_empty !== 1'b0) begin errors++; $display("FAIL flush_irq got=%b exp=0", irq_empty); end
        cyc_read(24'd1);
        vectors++; if (rdata !== 32'h1) begin errors++; $display("FAIL flush_status got=%h exp=1", rdata); end
        vectors++; if (irq_empty !== 1'b0) begin errors++; $display("FAIL flush_irq2 got=%b exp=0", irq_empty); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        logic [23:0] d;
        int left = 40;
        int inburst = 0;
        int c;
        logic pushing, e_hit;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_irq = 1'b0; m_rdata = 32'd0;
        for (c = 0; c < 3000 && !(left == 0 && mq.size() == 0); c++) begin
            if (left > 0 && inburst >= 7 && mq.size() == 0) inburst = 0;
            pushing = (left > 0) && (inburst < 7);
            if (pushing) begin
                address_bus = BASE;
                wdata_bus   = $urandom;
                control_bus = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
                out_ready   = 1'($urandom_range(0, 1));
                sent.push_back(wdata_bus);
                left--; inburst++;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 5))
                    0, 1: begin address_bus = BASE + 24'($urandom_range(0, 5)); control_bus = 2'b10; end
                    2: begin address_bus = BASE + 24'd3; wdata_bus = $urandom; control_bus = 2'b01; end
                    3: begin address_bus = BASE + 24'd2; wdata_bus = 32'h2; control_bus = 2'b01; end
                    default: begin address_bus = 24'($urandom); control_bus = 2'b00; end
                endcase
            end
            @(negedge clk);
            d = address_bus - BASE;
            e_hit = (d < 24'd4) && (control_bus != 2'b00);
            vectors++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL wrap_valid c=%0d got=%b exp=%b", c, out_valid, (mq.size() != 0)); end
            vectors++; if (out_data !== ((mq.size() != 0) ? mq[0] : 32'd0)) begin errors++; $display("FAIL wrap_data c=%0d got=%h", c, out_data); end
            vectors++; if (irq_empty !== m_irq) begin errors++; $display("FAIL wrap_irq c=%0d got=%b exp=%b", c, irq_empty, m_irq); end
            vectors++; if (rdata !== m_rdata) begin errors++; $display("FAIL wrap_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata); end
            vectors++; if (hit !== e_hit) begin errors++; $display("FAIL wrap_hit c=%0d got=%b exp=%b", c, hit, e_hit); end
            if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
            model_step();
            @(posedge clk); #1;
        end
        control_bus = 2'b00; out_ready = 1'b0;
        vectors++; if (!(left == 0 && mq.size() == 0)) begin errors++; $display("FAIL wrap_timeout left=%0d queued=%0d exp 0/0", left, mq.size()); end
        vectors++; if (got.size() != sent.size()) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== sent[i]) begin errors++; $display("FAIL wrap_order%0d got=%h exp=%h", i, got[i], sent[i]); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc_write(24'd0, $urandom | 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== 32'd0) begin errors++; $display("FAIL midrst_data got=%h exp=0", out_data); end
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b0;
        cyc_read(24'd1);
        vectors++; if (rdata !== 32'h1) begin errors++; $display("FAIL midrst_status got=%h exp=1", rdata); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid2 got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mmio_console.md
Name: mmio_console

Overview:
Memory-mapped output peripheral on the processor's data bus, alongside the RAM. It decodes a small register window at BASE_ADDR and buffers words written by compiled programs, such as print output, in a FIFO. It drains that FIFO to an external character/word sink over a valid/ready stream. The top level muxes its read data onto rdata_bus whenever hit is high.

Parameters:
BASE_ADDR, 24'hFFFF00, word address of register 0; the window is BASE_ADDR..BASE_ADDR+3.
DEPTH, 16, FIFO depth in 32-bit words; must be a power of two, 2..256.
AW, 4, log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
address_bus  input  24  word address from the processor.
wdata_bus  input  32  write data from the processor.
control_bus  input  2  bit0 = write enable, bit1 = read enable.
rdata  output  32  registered read data for the window.
hit  output  1  combinational; high when address_bus is in the window and control_bus != 0.
out_data  output  32  FIFO head word.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  sink accepts out_data this cycle.
irq_empty  output  1  registered; pulses for 1 cycle when the FIFO transitions non-empty -> empty.

Behaviour:
- Reset, asynchronous and active-high: FIFO empty, pointers and count = 0, overflow = 0, rdata = 0, out_valid = 0, out_data = 0, irq_empty = 0.
- Register map, as offsets from BASE_ADDR:
  - +0 TXDATA: a write pushes wdata_bus; a read returns 0.
  - +1 STATUS: read only. Bit0 = empty, bit1 = full, bit2 = overflow (sticky), bits[AW+8:8] = count, other bits 0.
  - +2 CONTROL: write only. Bit0 = 1 flushes the FIFO; bit1 = 1 clears overflow. A read returns 0.
  - +3: reserved; reads return 0 and writes are ignored.
- Bus cycle qualification:
  - Write when control_bus[0] = 1 and the address is in the window; it takes effect on that clk edge.
  - Read when control_bus == 2'b10 and the address is in the window. rdata is valid the cycle after, matching the synchronous RAM read latency.
  - control_bus == 2'b11 is treated as a write only; rdata holds its value.
  - Out-of-window accesses: no state change, rdata holds.
- STATUS read value: sampled at the edge of the read, i.e. before any same-cycle pop updates it.
- FIFO:
  - Circular buffer of DEPTH words with write/read pointers of AW bits that wrap modulo DEPTH.
  - count is AW+1 bits, range 0..DEPTH.
  - out_valid = (count != 0); out_data = mem[rd_ptr], combinational from registered state.
  - Pop occurs when out_valid && out_ready.
- Push latency: a word pushed into an empty FIFO appears on out_valid/out_data the next cycle. There is no fall-through in the same cycle.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds even when full, because the pop frees the slot, so no overflow is flagged.
- Push when full with no pop: the word is dropped, overflow is set to 1, and pointers and count are unchanged.
- Pop when empty: impossible by construction; out_ready is ignored.
- Flush (CONTROL bit0):
  - Pointers and count go to 0 at that edge and out_valid drops the next cycle.
  - A concurrent pop that cycle is discarded; the flush wins.
- Overflow clear and a push-when-full on the same edge cannot occur, because there is a single address per cycle.
- irq_empty: set for exactly one cycle when count goes from nonzero to 0 by a pop. Not asserted on flush or reset.
- out_data must stay stable while out_valid && !out_ready, as required by the sink protocol.
- Reset asserted mid-transfer: all state clears immediately, asynchronously. No stale word is presented after reset deasserts.

Test Plan:
- After reset, read STATUS -> rdata = 32'h0000_0001 one cycle later; out_valid = 0; hit = 1 during the access.
- With out_ready = 0, write 32'h41, 32'h42, 32'h43 to TXDATA -> out_valid rises the cycle after the first write, out_data = 32'h41, STATUS count = 3. Then set out_ready = 1 -> 41, 42, 43 are delivered on consecutive cycles, and irq_empty pulses once the cycle after the last pop.
- With out_ready = 0, push 17 words (values 0..16) -> full = 1, overflow = 1, and words 0..15 drain in order with 16 absent. Write CONTROL = 2 -> overflow = 0.
- With the FIFO full, push 32'hAA while out_ready = 1 -> no overflow, count stays 16, and 32'hAA is the last word drained.
- With 5 words queued, write CONTROL = 1 while out_ready = 1 -> out_valid = 0 the next cycle, count = 0, and no irq_empty.
- Wrap: push and drain 40 words in bursts of 7 -> output order exactly matches input order. Assert reset mid-burst -> out_valid = 0 immediately and STATUS = 1 after release.
